// File: rtl/calc_pkg.sv
// Shared opcode and FSM-state definitions for the calculator execution path.
// Also used by the result mux and the memory blocks.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_FINISH  = 2'd2
  } state_e;

endpackage

// File: rtl/calc_exec_unit_if.sv
// Request/result bundle between operand capture and the execution unit.
// start is accepted on any rising edge where busy==0; done pulses for exactly one cycle
// when result/remainder/borrow/div_by_zero update, and those hold until the next done.
interface calc_exec_unit_if #(parameter int WIDTH = 4);
  logic                 start;
  logic [1:0]           op_sel;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     remainder;
  logic                 borrow;
  logic                 div_by_zero;

  modport master (
    output start, op_sel, a, b,
    input  busy, done, result, remainder, borrow, div_by_zero
  );

  modport slave (
    input  start, op_sel, a, b,
    output busy, done, result, remainder, borrow, div_by_zero
  );
endinterface

// File: rtl/calc_divider_seq.sv
// Restoring divider, one quotient bit per step_en cycle, MSB first.
// quotient/remainder show the values after the step being taken this cycle.
module calc_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step_en,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_step
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    fits      = (shifted >= {1'b0, dvs_q});
    remainder = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotient  = {quo_q[WIDTH-2:0], fits};
    last_step = step_en && (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step_en) begin
      quo_q <= quotient;
      rem_q <= remainder;
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/calc_exec_unit.sv
// Registered ADD/SUB/MUL/DIV unit with start/done handshake. The FINISH state is the
// done cycle itself, so a start seen there is accepted exactly as in IDLE.
module calc_exec_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  calc_exec_unit_if.slave  bus,
  output state_e           dbg_state_o
);
  state_e state_q, state_d;

  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               borrow_q, borrow_d;
  logic               dbz_q, dbz_d;

  logic               div_load, div_step, div_last;
  logic [WIDTH-1:0]   div_quo, div_rem;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic               can_accept, b_zero;

  assign sum        = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff       = bus.a - bus.b;
  assign prod       = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
  assign can_accept = bus.start && (state_q != ST_DIV_RUN);
  assign b_zero     = (bus.b == '0);

  calc_divider_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .step_en   (div_step),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last_step (div_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      borrow_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      borrow_q <= borrow_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (can_accept) state_d = (bus.op_sel == OP_DIV && !b_zero) ? ST_DIV_RUN : ST_FINISH;
        else            state_d = ST_IDLE;
      end
      ST_DIV_RUN: if (div_last) state_d = ST_FINISH;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Every completing op rewrites all four result registers so stale flags never survive.
  always_comb begin
    div_load = 1'b0;
    div_step = (state_q == ST_DIV_RUN);
    result_d = result_q;
    rem_d    = rem_q;
    borrow_d = borrow_q;
    dbz_d    = dbz_q;
    if (can_accept) begin
      unique case (bus.op_sel)
        OP_ADD: begin
          result_d = {{(WIDTH-1){1'b0}}, sum};
          rem_d = '0; borrow_d = 1'b0; dbz_d = 1'b0;
        end
        OP_SUB: begin
          result_d = {{WIDTH{1'b0}}, diff};
          rem_d = '0; borrow_d = (bus.a < bus.b); dbz_d = 1'b0;
        end
        OP_MUL: begin
          result_d = prod;
          rem_d = '0; borrow_d = 1'b0; dbz_d = 1'b0;
        end
        OP_DIV: begin
          if (b_zero) begin
            result_d = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            rem_d = bus.a; borrow_d = 1'b0; dbz_d = 1'b1;
          end else begin
            div_load = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (div_last) begin
      result_d = {{WIDTH{1'b0}}, div_quo};
      rem_d = div_rem; borrow_d = 1'b0; dbz_d = 1'b0;
    end
  end

  assign bus.busy        = (state_q == ST_DIV_RUN);
  assign bus.done        = (state_q == ST_FINISH);
  assign bus.result      = result_q;
  assign bus.remainder   = rem_q;
  assign bus.borrow      = borrow_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_calc_exec_unit.sv
// Directed bench for calc_exec_unit at WIDTH=4 and WIDTH=8.
module tb_calc_exec_unit;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_exec_unit_if #(.WIDTH(4)) bus4 ();
  calc_exec_unit_if #(.WIDTH(8)) bus8 ();
  state_e st4, st8;

  calc_exec_unit #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(bus4), .dbg_state_o(st4));
  calc_exec_unit #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state_o(st8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bus4.start = 1'b1; bus4.op_sel = op; bus4.a = a; bus4.b = b;
    tick();
    bus4.start = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.start = 1'b1; bus8.op_sel = op; bus8.a = a; bus8.b = b;
    tick();
    bus8.start = 1'b0;
  endtask

  task automatic chk4(input string tag, input logic done, input logic busy,
                      input logic [7:0] res, input logic [3:0] rem,
                      input logic borrow, input logic dbz);
    chk({tag, ".done"},   64'(bus4.done), 64'(done));
    chk({tag, ".busy"},   64'(bus4.busy), 64'(busy));
    chk({tag, ".result"}, 64'(bus4.result), 64'(res));
    chk({tag, ".rem"},    64'(bus4.remainder), 64'(rem));
    chk({tag, ".borrow"}, 64'(bus4.borrow), 64'(borrow));
    chk({tag, ".dbz"},    64'(bus4.div_by_zero), 64'(dbz));
  endtask

  initial begin
    bus4.start = 1'b0; bus4.op_sel = 2'b00; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.op_sel = 2'b00; bus8.a = '0; bus8.b = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk4("reset", 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    chk("reset.state", 64'(st4), 64'(ST_IDLE));
    chk("reset8.result", 64'(bus8.result), 64'h0);

    issue4(OP_ADD, 4'd9, 4'd8);
    chk4("add_9_8", 1'b1, 1'b0, 8'h11, 4'h0, 1'b0, 1'b0);

    // back-to-back: start issued in the done cycle
    issue4(OP_SUB, 4'd3, 4'd5);
    chk4("sub_3_5", 1'b1, 1'b0, 8'h0E, 4'h0, 1'b1, 1'b0);
    issue4(OP_SUB, 4'd5, 4'd3);
    chk4("sub_5_3", 1'b1, 1'b0, 8'h02, 4'h0, 1'b0, 1'b0);
    bus4.a = 4'd15; bus4.b = 4'd15; bus4.op_sel = OP_MUL;
    tick();
    chk4("hold_sub", 1'b0, 1'b0, 8'h02, 4'h0, 1'b0, 1'b0);

    issue4(OP_MUL, 4'd15, 4'd15);
    chk4("mul_15_15", 1'b1, 1'b0, 8'hE1, 4'h0, 1'b0, 1'b0);
    tick();

    // DIV 13/3: busy N+1..N+4, done N+5; start at N+2 ignored
    issue4(OP_DIV, 4'd13, 4'd3);
    chk4("div_n1", 1'b0, 1'b1, 8'hE1, 4'h0, 1'b0, 1'b0);
    chk("div_n1.state", 64'(st4), 64'(ST_DIV_RUN));
    tick();
    bus4.start = 1'b1; bus4.op_sel = OP_ADD; bus4.a = 4'd1; bus4.b = 4'd1;
    tick();
    bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0;
    chk4("div_n3", 1'b0, 1'b1, 8'hE1, 4'h0, 1'b0, 1'b0);
    tick();
    chk4("div_n4", 1'b0, 1'b1, 8'hE1, 4'h0, 1'b0, 1'b0);
    tick();
    chk4("div_13_3", 1'b1, 1'b0, 8'h04, 4'h1, 1'b0, 1'b0);
    tick();
    chk4("div_hold", 1'b0, 1'b0, 8'h04, 4'h1, 1'b0, 1'b0);

    issue4(OP_DIV, 4'd7, 4'd0);
    chk4("div_7_0", 1'b1, 1'b0, 8'h0F, 4'h7, 1'b0, 1'b1);
    issue4(OP_ADD, 4'd1, 4'd2);
    chk4("add_clear_dbz", 1'b1, 1'b0, 8'h03, 4'h0, 1'b0, 1'b0);

    issue4(OP_SUB, 4'd0, 4'd1);
    chk4("sub_0_1", 1'b1, 1'b0, 8'h0F, 4'h0, 1'b1, 1'b0);
    issue4(OP_ADD, 4'd15, 4'd15);
    chk4("add_15_15", 1'b1, 1'b0, 8'h1E, 4'h0, 1'b0, 1'b0);
    tick();

    // reset during DIV_RUN aborts with no done
    issue4(OP_DIV, 4'd13, 4'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk4("abort", 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    chk("abort.state", 64'(st4), 64'(ST_IDLE));
    tick(); tick(); tick();
    chk4("abort_nodone", 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    issue4(OP_ADD, 4'd2, 4'd2);
    chk4("add_2_2", 1'b1, 1'b0, 8'h04, 4'h0, 1'b0, 1'b0);

    // WIDTH=8 instance
    issue8(OP_MUL, 8'd255, 8'd255);
    chk("w8_mul.done",   64'(bus8.done), 64'h1);
    chk("w8_mul.result", 64'(bus8.result), 64'hFE01);
    tick();
    issue8(OP_DIV, 8'd200, 8'd7);
    for (int i = 1; i <= 7; i++) begin
      chk("w8_div.busy", 64'(bus8.busy), 64'h1);
      chk("w8_div.done", 64'(bus8.done), 64'h0);
      tick();
    end
    chk("w8_div.busy_n8", 64'(bus8.busy), 64'h1);
    tick();
    chk("w8_div.done_n9", 64'(bus8.done), 64'h1);
    chk("w8_div.busy_n9", 64'(bus8.busy), 64'h0);
    chk("w8_div.result",  64'(bus8.result), 64'd28);
    chk("w8_div.rem",     64'(bus8.remainder), 64'd4);
    chk("w8_div.dbz",     64'(bus8.div_by_zero), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
